// File: rtl/punc_control_if.sv
// PUnC control <-> datapath signal bundle.
// Optional macro PUNC_ILLEGAL_OP_EN adds the illegal_op flag to the bundle.
// master: the control FSM (drives strobes/selects, reads IR and branch condition).
// slave : the datapath (drives IR and branch condition, reads strobes/selects).
interface punc_control_if;
    logic [15:0] ir_out;
    logic        nzp_match;
    logic        pc_ld;
    logic        pc_clr;
    logic        pc_inc;
    logic [1:0]  pc_sel;
    logic        ir_ld;
    logic        ir_clr;
    logic        dmem_rd;
    logic        dmem_wr;
    logic [1:0]  dmem_r_addr_sel;
    logic [1:0]  dmem_w_addr_sel;
    logic [1:0]  rf_w_data_sel;
    logic        rf_w_addr_sel;
    logic        rf_w_wr;
    logic        rf_rp_addr_sel;
    logic        rf_rp_rd;
    logic        rf_rq_rd;
    logic        temp_ld;
    logic        nzp_ld;
    logic        nzp_clr;
    logic [1:0]  alu_sel;
    logic        alu_in_a_sel;
    logic        halted;
`ifdef PUNC_ILLEGAL_OP_EN
    logic        illegal_op;
`endif

    modport master (
        input  ir_out, nzp_match,
        output pc_ld, pc_clr, pc_inc, pc_sel, ir_ld, ir_clr,
               dmem_rd, dmem_wr, dmem_r_addr_sel, dmem_w_addr_sel,
               rf_w_data_sel, rf_w_addr_sel, rf_w_wr, rf_rp_addr_sel,
               rf_rp_rd, rf_rq_rd, temp_ld, nzp_ld, nzp_clr,
               alu_sel, alu_in_a_sel, halted
`ifdef PUNC_ILLEGAL_OP_EN
               , illegal_op
`endif
    );

    modport slave (
        output ir_out, nzp_match,
        input  pc_ld, pc_clr, pc_inc, pc_sel, ir_ld, ir_clr,
               dmem_rd, dmem_wr, dmem_r_addr_sel, dmem_w_addr_sel,
               rf_w_data_sel, rf_w_addr_sel, rf_w_wr, rf_rp_addr_sel,
               rf_rp_rd, rf_rq_rd, temp_ld, nzp_ld, nzp_clr,
               alu_sel, alu_in_a_sel, halted
`ifdef PUNC_ILLEGAL_OP_EN
               , illegal_op
`endif
    );
endinterface

// File: rtl/punc_control.sv
// PUnC LC3 multi-cycle control FSM: INIT -> FETCH -> DECODE -> EXEC [-> EXEC2].
// All strobes are decoded from the registered state and the current IR only.
// Optional macro PUNC_ILLEGAL_OP_EN: opcodes 1000/1101 halt and raise illegal_op.
module punc_control (
    input  logic            clk,
    input  logic            rst,   // asynchronous, active-low
    punc_control_if.master  bus
);

    localparam logic [2:0] ST_INIT   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_EXEC2  = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [3:0] w_opcode;
    logic       w_halt_op;
    logic       w_unused_ir;

    logic       w_pc_ld, w_pc_clr, w_pc_inc;
    logic [1:0] w_pc_sel;
    logic       w_ir_ld, w_ir_clr;
    logic       w_dmem_rd, w_dmem_wr;
    logic [1:0] w_dmem_r_addr_sel, w_dmem_w_addr_sel;
    logic [1:0] w_rf_w_data_sel;
    logic       w_rf_w_addr_sel, w_rf_w_wr;
    logic       w_rf_rp_addr_sel, w_rf_rp_rd, w_rf_rq_rd;
    logic       w_temp_ld, w_nzp_ld, w_nzp_clr;
    logic [1:0] w_alu_sel;
    logic       w_alu_in_a_sel, w_halted;

    assign w_opcode    = bus.ir_out[15:12];
    assign w_unused_ir = ^{bus.ir_out[10:6], bus.ir_out[4:0]};

`ifdef PUNC_ILLEGAL_OP_EN
    logic r_illegal_op;
    logic w_illegal_dec;

    assign w_illegal_dec = (w_opcode == 4'b1000) || (w_opcode == 4'b1101);
    assign w_halt_op     = (w_opcode == OP_HALT) || w_illegal_dec;

    // Sticky illegal-opcode flag, captured as DECODE sends the FSM to HALT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_illegal_op <= 1'b0;
        else if (r_state == ST_DECODE && w_illegal_dec)
            r_illegal_op <= 1'b1;
    end

    assign bus.illegal_op = r_illegal_op;
`else
    assign w_halt_op = (w_opcode == OP_HALT);
`endif

    // State register; reset aborts any in-flight instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= ST_INIT;
        else
            r_state <= w_next;
    end

    // Next-state sequencing.
    always_comb begin
        w_next = ST_INIT;
        case (r_state)
            ST_INIT:   w_next = ST_FETCH;
            ST_FETCH:  w_next = ST_DECODE;
            ST_DECODE: w_next = w_halt_op ? ST_HALT : ST_EXEC;
            ST_EXEC:   w_next = (w_opcode == OP_LDI || w_opcode == OP_STI) ? ST_EXEC2 : ST_FETCH;
            ST_EXEC2:  w_next = ST_FETCH;
            ST_HALT:   w_next = ST_HALT;
            default:   w_next = ST_INIT;
        endcase
    end

    // Datapath control decode from state and opcode.
    always_comb begin
        w_pc_ld = 1'b0;           w_pc_clr = 1'b0;          w_pc_inc = 1'b0;
        w_pc_sel = 2'd0;          w_ir_ld = 1'b0;           w_ir_clr = 1'b0;
        w_dmem_rd = 1'b0;         w_dmem_wr = 1'b0;
        w_dmem_r_addr_sel = 2'd0; w_dmem_w_addr_sel = 2'd0;
        w_rf_w_data_sel = 2'd0;   w_rf_w_addr_sel = 1'b0;   w_rf_w_wr = 1'b0;
        w_rf_rp_addr_sel = 1'b0;  w_rf_rp_rd = 1'b0;        w_rf_rq_rd = 1'b0;
        w_temp_ld = 1'b0;         w_nzp_ld = 1'b0;          w_nzp_clr = 1'b0;
        w_alu_sel = 2'd0;         w_alu_in_a_sel = 1'b0;    w_halted = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_pc_clr  = 1'b1;
                w_ir_clr  = 1'b1;
                w_nzp_clr = 1'b1;
            end
            ST_FETCH: begin
                w_dmem_rd = 1'b1;
                w_ir_ld   = 1'b1;
                w_pc_inc  = 1'b1;
            end
            ST_EXEC: begin
                case (w_opcode)
                    OP_ADD, OP_AND: begin
                        w_alu_sel        = (w_opcode == OP_ADD) ? 2'd1 : 2'd2;
                        w_alu_in_a_sel   = bus.ir_out[5];
                        w_rf_rp_addr_sel = 1'b1;
                        w_rf_w_addr_sel  = 1'b1;
                        w_rf_w_wr        = 1'b1;
                        w_nzp_ld         = 1'b1;
                    end
                    OP_NOT: begin
                        w_alu_sel       = 2'd3;
                        w_rf_w_addr_sel = 1'b1;
                        w_rf_w_wr       = 1'b1;
                        w_nzp_ld        = 1'b1;
                    end
                    OP_BR: begin
                        w_pc_ld = bus.nzp_match;
                    end
                    OP_JMP: begin
                        w_pc_sel = 2'd2;
                        w_pc_ld  = 1'b1;
                    end
                    OP_JSR: begin
                        // R7 <= PC and PC load share one edge, so JSRR reads the old R7.
                        w_pc_sel        = bus.ir_out[11] ? 2'd1 : 2'd2;
                        w_pc_ld         = 1'b1;
                        w_rf_w_data_sel = 2'd3;
                        w_rf_w_wr       = 1'b1;
                    end
                    OP_LD, OP_LDR: begin
                        w_dmem_r_addr_sel = (w_opcode == OP_LD) ? 2'd1 : 2'd3;
                        w_rf_w_data_sel   = 2'd2;
                        w_rf_w_addr_sel   = 1'b1;
                        w_rf_w_wr         = 1'b1;
                        w_nzp_ld          = 1'b1;
                    end
                    OP_LEA: begin
                        w_rf_w_data_sel = 2'd1;
                        w_rf_w_addr_sel = 1'b1;
                        w_rf_w_wr       = 1'b1;
                        w_nzp_ld        = 1'b1;
                    end
                    OP_ST, OP_STR: begin
                        w_dmem_w_addr_sel = (w_opcode == OP_ST) ? 2'd0 : 2'd2;
                        w_dmem_wr         = 1'b1;
                    end
                    OP_LDI: begin
                        // First hop parks the pointer in DR; flags wait for the final value.
                        w_dmem_r_addr_sel = 2'd1;
                        w_rf_w_data_sel   = 2'd2;
                        w_rf_w_addr_sel   = 1'b1;
                        w_rf_w_wr         = 1'b1;
                    end
                    OP_STI: begin
                        w_dmem_r_addr_sel = 2'd1;
                        w_temp_ld         = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_EXEC2: begin
                if (w_opcode == OP_LDI) begin
                    w_dmem_r_addr_sel = 2'd2;
                    w_rf_w_data_sel   = 2'd2;
                    w_rf_w_addr_sel   = 1'b1;
                    w_rf_w_wr         = 1'b1;
                    w_nzp_ld          = 1'b1;
                end else if (w_opcode == OP_STI) begin
                    w_dmem_w_addr_sel = 2'd1;
                    w_dmem_wr         = 1'b1;
                end
            end
            ST_HALT: w_halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.pc_ld           = w_pc_ld;
    assign bus.pc_clr          = w_pc_clr;
    assign bus.pc_inc          = w_pc_inc;
    assign bus.pc_sel          = w_pc_sel;
    assign bus.ir_ld           = w_ir_ld;
    assign bus.ir_clr          = w_ir_clr;
    assign bus.dmem_rd         = w_dmem_rd;
    assign bus.dmem_wr         = w_dmem_wr;
    assign bus.dmem_r_addr_sel = w_dmem_r_addr_sel;
    assign bus.dmem_w_addr_sel = w_dmem_w_addr_sel;
    assign bus.rf_w_data_sel   = w_rf_w_data_sel;
    assign bus.rf_w_addr_sel   = w_rf_w_addr_sel;
    assign bus.rf_w_wr         = w_rf_w_wr;
    assign bus.rf_rp_addr_sel  = w_rf_rp_addr_sel;
    assign bus.rf_rp_rd        = w_rf_rp_rd;
    assign bus.rf_rq_rd        = w_rf_rq_rd;
    assign bus.temp_ld         = w_temp_ld;
    assign bus.nzp_ld          = w_nzp_ld;
    assign bus.nzp_clr         = w_nzp_clr;
    assign bus.alu_sel         = w_alu_sel;
    assign bus.alu_in_a_sel    = w_alu_in_a_sel;
    assign bus.halted          = w_halted;

endmodule

// File: doc/punc_control.md
Name: punc_control

Overview:
- Multi-cycle control FSM for the PUnC LC3 processor.
- Sequences the PUnC datapath through INIT/FETCH/DECODE/EXECUTE by decoding the instruction register (ir_out) and the branch condition (nzp_match).
- Drives every mux select, load, clear and write strobe of the datapath.
- Instantiated beside the datapath inside the PUnC top level.

Parameters:
None.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset; one clock; reset is asynchronous and active-low
ir_out  in  16  current instruction from the datapath IR
nzp_match  in  1  BR condition true, from the datapath
pc_ld  out  1  load PC from the PC mux
pc_clr  out  1  clear PC to 0
pc_inc  out  1  PC <= PC+1
pc_sel  out  2  0=PC+sext(ir[8:0]), 1=PC+sext(ir[10:0]), 2=Rq data
ir_ld  out  1  IR <= mem[r_addr]
ir_clr  out  1  IR <= 0
dmem_rd  out  1  memory read qualifier
dmem_wr  out  1  memory write enable
dmem_r_addr_sel  out  2  0=PC, 1=PC+off9, 2=Rp data, 3=Rq+off6
dmem_w_addr_sel  out  2  0=PC+off9, 1=temp, 2=Rq+off6
rf_w_data_sel  out  2  0=ALU, 1=PC+off9, 2=mem read data, 3=PC
rf_w_addr_sel  out  1  0=R7, 1=ir[11:9]
rf_w_wr  out  1  register-file write enable
rf_rp_addr_sel  out  1  0=ir[11:9], 1=ir[2:0]
rf_rp_rd  out  1  Rp read qualifier (one line each for Rp, Rq in RTL)
rf_rq_rd  out  1  Rq read qualifier
temp_ld  out  1  temp <= mem read data
nzp_ld  out  1  NZP <= flags of rf write data
nzp_clr  out  1  clear NZP
alu_sel  out  2  0=PassA, 1=ADD, 2=AND, 3=NOT Rq
alu_in_a_sel  out  1  0=Rp data, 1=sext(ir[4:0])
halted  out  1  high while in HALT

Behaviour:
- State register: INIT, FETCH, DECODE, EXEC, EXEC2, HALT.
- Outputs are a pure function of the registered state and ir_out. Every output is 0 unless listed for the state.
- rst low: state forced to INIT asynchronously. Reset output values: pc_clr=ir_clr=nzp_clr=1, all other outputs 0, halted=0.
- INIT: assert the three clears; next state FETCH.
- FETCH: dmem_rd=1, r_addr_sel=0, ir_ld=1, pc_inc=1; next state DECODE.
- DECODE: no strobes; next state EXEC, or HALT if ir[15:12]=1111.
- EXEC, by opcode; next state FETCH unless noted:
  - ADD(0001)/AND(0101): alu_sel=1/2, alu_in_a_sel=ir[5], rp_sel=1, w_addr_sel=1, w_data_sel=0, rf_w_wr, nzp_ld.
  - NOT(1001): alu_sel=3, w_addr_sel=1, rf_w_wr, nzp_ld.
  - BR(0000): pc_sel=0, pc_ld=nzp_match.
  - JMP/RET(1100): pc_sel=2, pc_ld.
  - JSR(0100): w_addr_sel=0, w_data_sel=3, rf_w_wr, pc_ld. pc_sel=1 if ir[11]=1, else 2 (JSRR). R7 write and PC load occur on the same edge; JSRR R7 uses the old R7 value.
  - LD(0010)/LDR(0110): r_addr_sel=1/3, w_data_sel=2, w_addr_sel=1, rf_w_wr, nzp_ld.
  - LEA(1110): w_data_sel=1, w_addr_sel=1, rf_w_wr, nzp_ld.
  - ST(0011)/STR(0111): rp_sel=0, w_addr_sel=0/2, dmem_wr.
  - LDI(1010): EXEC performs R[DR] <= mem[PC+off9] with no nzp; EXEC2 uses r_addr_sel=2, rp_sel=0, w_data_sel=2, rf_w_wr, nzp_ld.
  - STI(1011): EXEC does temp_ld with r_addr_sel=1; EXEC2 does dmem_w_addr_sel=1, rp_sel=0, dmem_wr.
  - 1000 and 1101: no strobes (NOP).
- HALT: absorbing; halted=1, no strobes. Exit only via rst.
- PC has already been incremented in FETCH, so every PC-relative offset uses PC+1.
- Reset asserted mid-EXEC/EXEC2 aborts the instruction. Strobes drop immediately; a pending write is not performed on the next edge.

Optional Feature:
PUNC_ILLEGAL_OP_EN
- Defined: adds output illegal_op (1 bit, reset 0). Opcodes 1000 and 1101 go from DECODE to HALT, and illegal_op sets and stays high until rst.
- Undefined: no such port; both opcodes execute as NOP.

Test Plan:
- rst low for 2 cycles then high -> outputs pc_clr, ir_clr, nzp_clr =1 during INIT; the next state is FETCH with ir_ld=1, pc_inc=1, dmem_r_addr_sel=0.
- ir_out=0x1261 (ADD R1,R1,#1) at EXEC -> alu_sel=1, alu_in_a_sel=1, rf_w_addr_sel=1, rf_w_wr=1, nzp_ld=1; the following cycle is FETCH.
- ir_out=0x0402 (BRz) with nzp_match=0 -> pc_ld=0; rerun with nzp_match=1 -> pc_ld=1, pc_sel=0.
- ir_out=0xA005 (LDI R0) -> EXEC: r_addr_sel=1, rf_w_wr=1, nzp_ld=0; EXEC2: r_addr_sel=2, rp_sel=0, rf_w_wr=1, nzp_ld=1; then FETCH.
- ir_out=0xB003 (STI) -> EXEC: temp_ld=1, dmem_wr=0; EXEC2: dmem_w_addr_sel=1, dmem_wr=1; rst dropped during EXEC2 -> dmem_wr=0 immediately.
- ir_out=0xF025 -> DECODE then HALT with halted=1 for 20 cycles and no strobes. ir_out=0x8000 -> NOP if macro undefined; HALT with illegal_op=1 if defined.
